tlb_plru_tree: RTL and testbench
================================

// Module: tlb_plru_tree
// PURPOSE
//  Parametrised tree pseudo-LRU replacement engine for fully-associative TLBs (ITLB/DTLB, any power-of-2 size).
//  Tracks recency from one-hot hits and committed refills. Picks a refill victim with invalid-first priority
//  and a per-entry lock mask; locked entries are never chosen. Sits beside the TLB array in mms.
//  Victim handshake is registered: the index stays stable from grant until commit.
// PARAMETERS
//  ENTRIES  32                 number of TLB entries; power of 2, >= 2
//  IDX_W    $clog2(ENTRIES)    entry index width (derived; do not override)
// PORTS
//  clk_i            in   1        clock
//  rst_i            in   1        synchronous reset, active-high
//  flush_i          in   1        clear tree state, abort pending victim
//  entry_valid_i    in   ENTRIES  per-entry valid
//  lock_i           in   ENTRIES  per-entry lock; 1 = never a victim
//  hit_vld_i        in   1        lookup hit strobe
//  hit_onehot_i     in   ENTRIES  one-hot hit vector, qualified by hit_vld_i
//  victim_req_i     in   1        request a victim (sampled in IDLE only)
//  refill_vld_i     in   1        commit refill into held victim (sampled in HOLD only)
//  victim_vld_o     out  1        victim held and valid
//  victim_idx_o     out  IDX_W    held victim index
//  victim_onehot_o  out  ENTRIES  one-hot of victim_idx_o; all-zero when victim_vld_o=0
//  victim_none_o    out  1        1-cycle pulse: request failed, every entry locked
//  multihit_o       out  1        1-cycle pulse: hit_vld_i with a zero or multi-hot vector
// BEHAVIOUR
//  Tree: ENTRIES-1 bits, heap order (root=0; children of k are 2k+1=lower half, 2k+2=upper half).
//   Bit 0 = victim side is lower half.
//  Touch(e): each node on the path to e is set to point away from e. All other bits are unchanged.
//  Victim select (comb, on current inputs):
//   (1) lowest index with valid=0 and lock=0;
//   (2) else walk from root; at each node follow the bit, unless that subtree is fully locked, then take the sibling;
//   (3) if all entries are locked: none.
//  FSM IDLE/HOLD:
//   - IDLE & victim_req_i & victim exists -> HOLD; next cycle victim_vld_o=1, idx/onehot registered (latency 1).
//   - IDLE & victim_req_i & all locked -> stay IDLE; victim_none_o=1 next cycle.
//   - HOLD: idx/onehot frozen, regardless of later hits, valid or lock changes.
//   - HOLD & refill_vld_i -> Touch(victim_idx_o), -> IDLE; victim_vld_o=0 next cycle.
//   - victim_req_i in HOLD and refill_vld_i in IDLE are ignored (no state change).
//  Hits: hit_vld_i with exactly one bit set -> Touch(hit) at the next edge.
//   Every hit updates the tree; repeated hits are not filtered.
//   Zero or multi-hot vector -> tree unchanged, multihit_o=1 next cycle.
//  Refill and valid hit in the same cycle: apply the refill touch first, then the hit touch; the hit wins on shared nodes.
//  flush_i: tree <- 0 and FSM <- IDLE next cycle (victim_vld_o=0). Takes priority over hit, refill and req in the same cycle.
//  Reset (rst_i=1 at an edge): tree=0, FSM=IDLE, all outputs 0. Reset mid-HOLD drops the victim with no commit.
//  Outputs are all registered. No combinational path from any input to any output.
// TESTING (ENTRIES=8)
//  1. After reset, valid=8'hF7, lock=0, req -> victim_vld_o=1 next cycle, idx=3, onehot=8'h08.
//  2. valid=8'hFF, tree=0: req -> idx 0; refill -> req -> idx 4; refill -> req -> idx 2.
//  3. valid=8'hFF, lock=8'h0F, tree=0: req -> idx 4. With lock=8'hFF: req -> victim_none_o 1-cycle pulse, victim_vld_o stays 0.
//  4. In HOLD at idx 0: hit 0, then change lock -> idx stays 0 until refill. Then hit_onehot=8'h03 -> multihit_o pulse, tree unchanged.
//  5. Same cycle: refill (idx 0) + hit 4 from tree=0 -> root=0 and node2=1, so the next req gives idx 2.
//     flush in HOLD -> victim_vld_o=0 next cycle, and the next req gives idx 0.

Source files
------------

// File: rtl/tlb_plru_tree.sv
`default_nettype none
// ============================================================================
//  Module      : tlb_plru_tree
//  Description : Tree pseudo-LRU replacement engine for a fully-associative
//                TLB. Tracks recency from one-hot hits and committed refills
//                and grants a refill victim with invalid-first priority and a
//                per-entry lock mask. The victim is held stable until commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlb_plru_tree #(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [ENTRIES-1:0] entry_valid_i,
  input  logic [ENTRIES-1:0] lock_i,
  input  logic               hit_vld_i,
  input  logic [ENTRIES-1:0] hit_onehot_i,
  input  logic               victim_req_i,
  input  logic               refill_vld_i,
  output logic               victim_vld_o,
  output logic [IDX_W-1:0]   victim_idx_o,
  output logic [ENTRIES-1:0] victim_onehot_o,
  output logic               victim_none_o,
  output logic               multihit_o
);

  // Tree node count and heap-ordered node+leaf vector width.
  localparam int NODES = ENTRIES - 1;
  localparam int HEAP  = 2 * ENTRIES - 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e               state_q;
  logic [NODES-1:0]     tree_q, tree_d;
  logic                 vld_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ENTRIES-1:0]   onehot_q;
  logic                 none_q;
  logic                 multihit_q;

  // Heap-ordered "subtree fully locked" flags; leaves live at NODES+e.
  logic [HEAP-1:0]      full_w;

  logic                 inv_found_w;
  logic [IDX_W-1:0]     inv_idx_w;
  logic [IDX_W-1:0]     walk_idx_w;
  logic [IDX_W:0]       walk_node_w;
  logic [IDX_W:0]       walk_lo_w;
  logic [IDX_W:0]       walk_hi_w;
  logic                 walk_up_w;
  logic [IDX_W-1:0]     vic_idx_w;
  logic                 vic_avail_w;

  logic                 hit_single_w;
  logic [IDX_W-1:0]     hit_idx_w;
  logic                 refill_commit_w;

  // Move every node on the path to e so that it points away from e.
  function automatic logic [NODES-1:0] f_touch(input logic [NODES-1:0] t,
                                               input logic [IDX_W-1:0] e);
    logic [NODES-1:0] r;
    logic [IDX_W:0]   node;
    r    = t;
    node = '0;
    for (int l = 0; l < IDX_W; l++) begin
      // e in the upper half -> victim side becomes the lower half (0).
      r[node] = ~e[IDX_W-1-l];
      node    = {node[IDX_W-1:0], 1'b0} + {{IDX_W{1'b0}}, 1'b1}
              + {{IDX_W{1'b0}}, e[IDX_W-1-l]};
    end
    return r;
  endfunction

  // Leaf lock flags feed the bottom of the fully-locked heap.
  generate
    for (genvar e = 0; e < ENTRIES; e++) begin : g_leaf_full
      assign full_w[NODES+e] = lock_i[e];
    end
  endgenerate

  // Each internal node is fully locked when every entry beneath it is locked.
  generate
    for (genvar l = 0; l < IDX_W; l++) begin : g_lvl_full
      for (genvar p = 0; p < (1 << l); p++) begin : g_pos_full
        assign full_w[(1 << l) - 1 + p] =
          &lock_i[p*(ENTRIES >> l) +: (ENTRIES >> l)];
      end
    end
  endgenerate

  // First-choice victim: lowest-index entry that is invalid and not locked.
  always_comb begin
    inv_found_w = 1'b0;
    inv_idx_w   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid_i[i] && !lock_i[i]) begin
        inv_found_w = 1'b1;
        inv_idx_w   = IDX_W'(i);
      end
    end
  end

  // Fallback victim: follow tree bits, steering around fully-locked subtrees.
  always_comb begin
    walk_node_w = '0;
    walk_idx_w  = '0;
    walk_lo_w   = '0;
    walk_hi_w   = '0;
    walk_up_w   = 1'b0;
    for (int l = 0; l < IDX_W; l++) begin
      walk_lo_w = {walk_node_w[IDX_W-1:0], 1'b0} + {{IDX_W{1'b0}}, 1'b1};
      walk_hi_w = walk_lo_w + {{IDX_W{1'b0}}, 1'b1};
      walk_up_w = tree_q[walk_node_w];
      if (!walk_up_w && full_w[walk_lo_w]) begin
        walk_up_w = 1'b1;
      end else if (walk_up_w && full_w[walk_hi_w]) begin
        walk_up_w = 1'b0;
      end
      walk_idx_w[IDX_W-1-l] = walk_up_w;
      walk_node_w = walk_up_w ? walk_hi_w : walk_lo_w;
    end
  end

  assign vic_idx_w   = inv_found_w ? inv_idx_w : walk_idx_w;
  assign vic_avail_w = ~full_w[0];

  // Hit decode: exactly-one-hot detection and binary encode of the hit entry.
  always_comb begin
    hit_single_w = (hit_onehot_i != '0) &&
                   ((hit_onehot_i & (hit_onehot_i - ENTRIES'(1))) == '0);
    hit_idx_w    = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit_onehot_i[i]) begin
        hit_idx_w = hit_idx_w | IDX_W'(i);
      end
    end
  end

  assign refill_commit_w = (state_q == S_HOLD) && refill_vld_i;

  // Next tree: flush clears; otherwise refill touch first, then hit touch.
  always_comb begin
    tree_d = tree_q;
    if (flush_i) begin
      tree_d = '0;
    end else begin
      if (refill_commit_w) begin
        tree_d = f_touch(tree_d, idx_q);
      end
      if (hit_vld_i && hit_single_w) begin
        tree_d = f_touch(tree_d, hit_idx_w);
      end
    end
  end

  // Tree state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tree_q <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

  // Victim handshake FSM with registered outputs and status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      onehot_q   <= '0;
      none_q     <= 1'b0;
      multihit_q <= 1'b0;
    end else begin
      none_q     <= 1'b0;
      multihit_q <= hit_vld_i && !hit_single_w && !flush_i;
      if (flush_i) begin
        state_q  <= S_IDLE;
        vld_q    <= 1'b0;
        idx_q    <= '0;
        onehot_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (victim_req_i) begin
              if (vic_avail_w) begin
                state_q  <= S_HOLD;
                vld_q    <= 1'b1;
                idx_q    <= vic_idx_w;
                onehot_q <= ENTRIES'(1) << vic_idx_w;
              end else begin
                none_q   <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (refill_vld_i) begin
              state_q  <= S_IDLE;
              vld_q    <= 1'b0;
              idx_q    <= '0;
              onehot_q <= '0;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            vld_q    <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
          end
        endcase
      end
    end
  end

  assign victim_vld_o    = vld_q;
  assign victim_idx_o    = idx_q;
  assign victim_onehot_o = onehot_q;
  assign victim_none_o   = none_q;
  assign multihit_o      = multihit_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_plru_tree.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlb_plru_tree
//  Description : Self-checking bench for tlb_plru_tree with ENTRIES=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_plru_tree;

  localparam int ENTRIES = 8;
  localparam int IDX_W   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] lock;
  logic               hit_vld;
  logic [ENTRIES-1:0] hit_oh;
  logic               req;
  logic               refill;
  logic               vld_o;
  logic [IDX_W-1:0]   idx_o;
  logic [ENTRIES-1:0] oh_o;
  logic               none_o;
  logic               mh_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] valid;
    logic [7:0] lock;
    logic       hv;
    logic [7:0] hoh;
    logic       req;
    logic       refill;
    logic       flush;
    logic       evld;
    logic [2:0] eidx;
    logic [7:0] eoh;
    logic       enone;
    logic       emh;
  } vec_t;

  typedef struct {
    logic       evld;
    logic [2:0] eidx;
    logic [7:0] eoh;
    logic       enone;
    logic       emh;
  } exp_t;

  vec_t tbl[36];
  exp_t exp_q[$];

  tlb_plru_tree #(.ENTRIES(ENTRIES)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .entry_valid_i   (valid),
    .lock_i          (lock),
    .hit_vld_i       (hit_vld),
    .hit_onehot_i    (hit_oh),
    .victim_req_i    (req),
    .refill_vld_i    (refill),
    .victim_vld_o    (vld_o),
    .victim_idx_o    (idx_o),
    .victim_onehot_o (oh_o),
    .victim_none_o   (none_o),
    .multihit_o      (mh_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] v, input logic [7:0] lk,
                              input logic hv, input logic [7:0] hoh,
                              input logic rq, input logic rf, input logic fl,
                              input logic ev, input logic [2:0] ei,
                              input logic [7:0] eo, input logic en,
                              input logic em);
    vec_t r;
    r.valid = v;  r.lock = lk; r.hv = hv; r.hoh = hoh;
    r.req = rq;   r.refill = rf; r.flush = fl;
    r.evld = ev;  r.eidx = ei; r.eoh = eo; r.enone = en; r.emh = em;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input int row);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, push its expectation, then
  // sample just after the next rising edge and compare against the queue.
  task automatic apply(input vec_t v, input int row);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    valid = v.valid; lock = v.lock; hit_vld = v.hv; hit_oh = v.hoh;
    req = v.req; refill = v.refill; flush = v.flush;
    e.evld = v.evld; e.eidx = v.eidx; e.eoh = v.eoh;
    e.enone = v.enone; e.emh = v.emh;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard row %0d: got empty queue expected one entry", row);
    end else begin
      got_e = exp_q.pop_front();
      chk("victim_vld", 32'(vld_o), 32'(got_e.evld), row);
      chk("victim_onehot", 32'(oh_o), 32'(got_e.eoh), row);
      chk("victim_none", 32'(none_o), 32'(got_e.enone), row);
      chk("multihit", 32'(mh_o), 32'(got_e.emh), row);
      if (got_e.evld) chk("victim_idx", 32'(idx_o), 32'(got_e.eidx), row);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_vld"}, 32'(vld_o), 32'd0, -1);
    chk({tag, "_idx"}, 32'(idx_o), 32'd0, -1);
    chk({tag, "_onehot"}, 32'(oh_o), 32'd0, -1);
    chk({tag, "_none"}, 32'(none_o), 32'd0, -1);
    chk({tag, "_multihit"}, 32'(mh_o), 32'd0, -1);
  endtask

  initial begin
    //              valid  lock   hv hoh    rq rf fl  ev idx oh     en em
    // Invalid-first victim after reset
    tbl[0]  = mk(8'hF7, 8'h00, 0, 8'h00, 1, 0, 0,  1, 3, 8'h08, 0, 0);
    tbl[1]  = mk(8'hF7, 8'h00, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(8'hFF, 8'h00, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0, 0);
    // PLRU walk sequence 0 -> 4 -> 2
    tbl[3]  = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 0, 8'h01, 0, 0);
    tbl[4]  = mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[5]  = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 4, 8'h10, 0, 0);
    tbl[6]  = mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[7]  = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 2, 8'h04, 0, 0);
    tbl[8]  = mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[9]  = mk(8'hFF, 8'h00, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0, 0);
    // Lock steering and all-locked
    tbl[10] = mk(8'hFF, 8'h0F, 0, 8'h00, 1, 0, 0,  1, 4, 8'h10, 0, 0);
    tbl[11] = mk(8'hFF, 8'h0F, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[12] = mk(8'hFF, 8'hFF, 0, 8'h00, 1, 0, 0,  0, 0, 8'h00, 1, 0);
    tbl[13] = mk(8'hFF, 8'hFF, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 0, 0);
    tbl[14] = mk(8'hFF, 8'h00, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0, 0);
    // HOLD stability, multihit, zero-hit
    tbl[15] = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 0, 8'h01, 0, 0);
    tbl[16] = mk(8'hFF, 8'h00, 1, 8'h01, 0, 0, 0,  1, 0, 8'h01, 0, 0);
    tbl[17] = mk(8'hFE, 8'h01, 0, 8'h00, 0, 0, 0,  1, 0, 8'h01, 0, 0);
    tbl[18] = mk(8'hFE, 8'h01, 0, 8'h00, 1, 0, 0,  1, 0, 8'h01, 0, 0);
    tbl[19] = mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[20] = mk(8'hFF, 8'h00, 1, 8'h03, 0, 0, 0,  0, 0, 8'h00, 0, 1);
    tbl[21] = mk(8'hFF, 8'h00, 0, 8'h00, 0, 0, 0,  0, 0, 8'h00, 0, 0);
    tbl[22] = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 4, 8'h10, 0, 0);
    tbl[23] = mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[24] = mk(8'hFF, 8'h00, 1, 8'h00, 0, 0, 0,  0, 0, 8'h00, 0, 1);
    tbl[25] = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 2, 8'h04, 0, 0);
    tbl[26] = mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[27] = mk(8'hFF, 8'h00, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0, 0);
    // Refill + hit same cycle, flush in HOLD
    tbl[28] = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 0, 8'h01, 0, 0);
    tbl[29] = mk(8'hFF, 8'h00, 1, 8'h10, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    tbl[30] = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 2, 8'h04, 0, 0);
    tbl[31] = mk(8'hFF, 8'h00, 0, 8'h00, 0, 0, 1,  0, 0, 8'h00, 0, 0);
    tbl[32] = mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0,  1, 0, 8'h01, 0, 0);
    tbl[33] = mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);
    // Invalid-first skips a locked invalid entry
    tbl[34] = mk(8'hF6, 8'h01, 0, 8'h00, 1, 0, 0,  1, 3, 8'h08, 0, 0);
    tbl[35] = mk(8'hF6, 8'h01, 0, 8'h00, 0, 1, 0,  0, 0, 8'h00, 0, 0);

    rst = 1'b1; flush = 1'b0; valid = 8'hFF; lock = 8'h00;
    hit_vld = 1'b0; hit_oh = 8'h00; req = 1'b0; refill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 36; i++) begin
      apply(tbl[i], i);
    end

    // Hand sequence: victim remains held across idle cycles, then reset
    // mid-HOLD drops it and the tree restarts from zero.
    apply(mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0, 1, 4, 8'h10, 0, 0), 100);
    apply(mk(8'hFF, 8'h00, 1, 8'h20, 0, 0, 0, 1, 4, 8'h10, 0, 0), 101);
    apply(mk(8'hFF, 8'h00, 0, 8'h00, 0, 0, 0, 1, 4, 8'h10, 0, 0), 102);
    @(negedge clk);
    rst = 1'b1; req = 1'b0; hit_vld = 1'b0; refill = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("midhold_reset");
    @(negedge clk);
    rst = 1'b0;
    apply(mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h01, 0, 0), 103);
    apply(mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0), 104);
    // Refill while IDLE is ignored: tree after touch(0) still points at 4.
    apply(mk(8'hFF, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0), 105);
    apply(mk(8'hFF, 8'h00, 0, 8'h00, 1, 0, 0, 1, 4, 8'h10, 0, 0), 106);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire
